// File: rtl/mux_pkg.sv
// Shared constants for the N:1 stream mux.
// Mode encodings and the index-width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
// Scans req starting at ptr, wrapping modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 3,
  localparam int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  // Descending scan so the closest requester after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (en && req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 valid/ready stream mux with fixed or round-robin select.
// Registered output stage; in_ready is combinational.
module mux_n_1_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int N     = 3,
  localparam int SW    = idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SW-1:0]    s,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    r_ptr;

  logic             w_load_en;
  logic             w_rr_vld;
  logic [SW-1:0]    w_rr_idx;
  logic             w_fix_vld;
  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_idx;
  logic             w_gnt_in_vld;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic [SW-1:0]    w_ptr_nxt;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .en      (mode == MODE_RR),
    .gnt_vld (w_rr_vld),
    .gnt_idx (w_rr_idx)
  );

  assign w_load_en = !r_valid || out_ready;
  assign w_fix_vld = int'(s) < N;

  always_comb begin
    w_gnt_vld = w_fix_vld;
    w_gnt_idx = s;
    if (mode == MODE_RR) begin
      w_gnt_vld = w_rr_vld;
      w_gnt_idx = w_rr_idx;
    end
  end

  always_comb begin
    w_gnt_in_vld = 1'b0;
    w_gnt_data   = '0;
    in_ready     = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == w_gnt_idx) begin
        w_gnt_in_vld = in_valid[k];
        w_gnt_data   = in_data[k*WIDTH +: WIDTH];
        in_ready[k]  = !reset && w_load_en && w_gnt_vld;
      end
    end
  end

  assign w_xfer    = !reset && w_load_en && w_gnt_vld && w_gnt_in_vld;
  assign w_ptr_nxt = (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + SW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load_en) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_data <= w_gnt_data;
          r_sel  <= w_gnt_idx;
        end
      end
      if (w_xfer && mode == MODE_RR)
        r_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
